// File: rtl/nanorv32_test_monitor.sv
// Test-verdict monitor for the nanorv32 core: watches retired instructions, decides
// pass/fail/unknown/illegal/timeout, and queues printf characters for a consumer.
module nanorv32_test_monitor #(
  parameter int                DATA_W         = 32,
  parameter logic [DATA_W-1:0] PASS_PC        = DATA_W'(32'h00000100),
  parameter logic [DATA_W-1:0] PRINTF_PC      = DATA_W'(32'h00000088),
  parameter logic [DATA_W-1:0] PASS_VAL       = DATA_W'(32'hCAFFE000),
  parameter logic [DATA_W-1:0] FAIL_VAL       = DATA_W'(32'hDEADD000),
  parameter int                TIMEOUT_CYCLES = 20000000,
  parameter int                CNT_W          = 32,
  parameter int                FIFO_DEPTH     = 16,
  parameter int                FIFO_AW        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ret_valid,
  input  logic [DATA_W-1:0] ret_pc,
  input  logic [DATA_W-1:0] a0,
  input  logic              illegal_instruction,
  output logic              done,
  output logic [2:0]        status,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready,
  output logic              line_flush,
  output logic              fifo_overflow,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  insn_count
);

  typedef enum logic [2:0] {
    ST_RUN          = 3'd0,
    ST_PASS         = 3'd1,
    ST_FAIL         = 3'd2,
    ST_FAIL_UNKNOWN = 3'd3,
    ST_ILLEGAL      = 3'd4,
    ST_TIMEOUT      = 3'd5
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic             r_done;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_insn_count;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [FIFO_AW:0] r_wptr;
  logic [FIFO_AW:0] r_rptr;
  logic             r_line_flush;
  logic             r_overflow;

  logic w_run, w_empty, w_full, w_pop, w_push_req, w_push_ok;
  logic w_pass_hit, w_timeout_hit;

  assign w_run         = (r_state == ST_RUN);
  assign w_empty       = (r_wptr == r_rptr);
  assign w_full        = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                         (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_pop         = !w_empty && char_ready;
  assign w_push_req    = w_run && ret_valid && (ret_pc == PRINTF_PC);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok     = w_push_req && (!w_full || w_pop);
  assign w_pass_hit    = ret_valid && (ret_pc == PASS_PC);
  assign w_timeout_hit = TO_EN && (r_cycle_count == TO_LAST);

  // Verdict FSM and RUN-time counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_done        <= 1'b0;
      r_cycle_count <= '0;
      r_insn_count  <= '0;
    end else if (w_run) begin
      r_cycle_count <= r_cycle_count + CNT_W'(1);
      if (ret_valid) r_insn_count <= r_insn_count + CNT_W'(1);
      if (illegal_instruction) begin
        r_state <= ST_ILLEGAL;
        r_done  <= 1'b1;
      end else if (w_pass_hit) begin
        r_done <= 1'b1;
        if (a0 == PASS_VAL)      r_state <= ST_PASS;
        else if (a0 == FAIL_VAL) r_state <= ST_FAIL;
        else                     r_state <= ST_FAIL_UNKNOWN;
      end else if (w_timeout_hit) begin
        r_state <= ST_TIMEOUT;
        r_done  <= 1'b1;
      end
    end
  end

  // Printf FIFO control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_line_flush <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_line_flush <= w_push_ok && (a0[7:0] == 8'h0A);
      if (w_push_req && !w_push_ok) r_overflow <= 1'b1;
      if (w_push_ok) r_wptr <= r_wptr + (FIFO_AW+1)'(1);
      if (w_pop)     r_rptr <= r_rptr + (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[FIFO_AW-1:0]] <= a0[7:0];
  end

  assign done          = r_done;
  assign status        = r_state;
  assign char_valid    = !w_empty;
  assign char_data     = w_empty ? 8'h00 : r_mem[r_rptr[FIFO_AW-1:0]];
  assign line_flush    = r_line_flush;
  assign fifo_overflow = r_overflow;
  assign cycle_count   = r_cycle_count;
  assign insn_count    = r_insn_count;

endmodule
